// File: rtl/ber_pkg.sv
// Shared types and helpers for the 16-QAM bit/symbol error-rate meter.
package ber_pkg;

    localparam int unsigned SYM_W  = 2;
    localparam int unsigned PAIR_W = 2 * SYM_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_SEARCH  = 2'd2,
        ST_MEASURE = 2'd3
    } ber_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [2:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {30'd0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ber_ref_delay.sv
// Reference symbol delay line: tap[sel] is the input delayed by sel+1 shifts.
module ber_ref_delay
    import ber_pkg::*;
#(
    parameter int unsigned MAX_DLY = 64,
    parameter int unsigned DLY_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [PAIR_W-1:0] din,
    input  logic [DLY_W-1:0]  sel,
    output logic [PAIR_W-1:0] tap
);

    logic [PAIR_W-1:0] line [MAX_DLY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MAX_DLY; i++) begin
                line[i] <= '0;
            end
        end else if (shift_en) begin
            line[0] <= din;
            for (int unsigned i = 1; i < MAX_DLY; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign tap = line[sel];

endmodule

// File: rtl/ber_meter.sv
// Error-rate meter: finds the rx delay against the reference, then counts errors per window.
// Optional self-test input err_inject is present when BER_ERR_INJECT_EN is defined.
module ber_meter
    import ber_pkg::*;
#(
    parameter int unsigned MAX_DLY  = 64,
    parameter int unsigned DLY_W    = 6,
    parameter int unsigned ACQ_LEN  = 32,
    parameter int unsigned LOSS_LEN = 16,
    parameter int unsigned WIN_LOG2 = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_clk_ena,
    input  logic             enable,
    input  logic             clear,
`ifdef BER_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    input  logic [1:0]       ref_i,
    input  logic [1:0]       ref_q,
    input  logic [1:0]       rx_i,
    input  logic [1:0]       rx_q,
    output logic             locked,
    output logic [DLY_W-1:0] delay,
    output logic             done,
    output logic [31:0]      bit_errs,
    output logic [31:0]      sym_errs,
    output logic [15:0]      win_count
);

    localparam int unsigned MATCH_W = $clog2(ACQ_LEN + 1);
    localparam int unsigned RUN_W   = $clog2(LOSS_LEN + 1);

    ber_state_t          state_q, state_d;
    logic [DLY_W-1:0]    fill_cnt;
    logic [MATCH_W-1:0]  match_cnt;
    logic [RUN_W-1:0]    run_cnt;
    logic [WIN_LOG2-1:0] sym_cnt;
    logic [31:0]         bit_acc, sym_acc;
    logic [31:0]         bit_acc_nxt, sym_acc_nxt;
    logic [DLY_W-1:0]    delay_q;
    logic                done_q;
    logic [31:0]         bit_errs_q, sym_errs_q;
    logic [15:0]         win_count_q;

    logic [PAIR_W-1:0]   tap, rx_sym, err_vec;
    logic                sym_err, fill_done, acq_done, loss, win_end;

    ber_ref_delay #(
        .MAX_DLY (MAX_DLY),
        .DLY_W   (DLY_W)
    ) u_ref_delay (
        .clk      (clk),
        .reset    (reset),
        .shift_en (sym_clk_ena && (state_q != ST_IDLE)),
        .din      ({ref_i, ref_q}),
        .sel      (delay_q),
        .tap      (tap)
    );

`ifdef BER_ERR_INJECT_EN
    assign rx_sym = {rx_i[1], rx_i[0] ^ err_inject, rx_q};
`else
    assign rx_sym = {rx_i, rx_q};
`endif

    assign err_vec     = rx_sym ^ tap;
    assign sym_err     = |err_vec;
    assign fill_done   = (fill_cnt == DLY_W'(MAX_DLY - 1));
    assign acq_done    = !sym_err && (match_cnt == MATCH_W'(ACQ_LEN - 1));
    assign loss        = sym_err && (run_cnt == RUN_W'(LOSS_LEN - 1));
    assign win_end     = (sym_cnt == '1);
    assign bit_acc_nxt = sat_add32(bit_acc, popcount4(err_vec));
    assign sym_acc_nxt = sat_add32(sym_acc, {2'b00, sym_err});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (clear) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_FILL;
                ST_FILL:    if (sym_clk_ena && fill_done) state_d = ST_SEARCH;
                ST_SEARCH:  if (sym_clk_ena && acq_done)  state_d = ST_MEASURE;
                ST_MEASURE: if (sym_clk_ena && loss)      state_d = ST_SEARCH;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // enable low / clear wipe the run counters but leave delay and published results alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt    <= '0;
            match_cnt   <= '0;
            run_cnt     <= '0;
            sym_cnt     <= '0;
            bit_acc     <= '0;
            sym_acc     <= '0;
            delay_q     <= '0;
            done_q      <= 1'b0;
            bit_errs_q  <= '0;
            sym_errs_q  <= '0;
            win_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (!enable || clear) begin
                fill_cnt  <= '0;
                match_cnt <= '0;
                run_cnt   <= '0;
                sym_cnt   <= '0;
                bit_acc   <= '0;
                sym_acc   <= '0;
            end else if (sym_clk_ena) begin
                case (state_q)
                    ST_FILL: begin
                        if (fill_done) begin
                            fill_cnt  <= '0;
                            delay_q   <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + DLY_W'(1);
                        end
                    end
                    ST_SEARCH: begin
                        if (sym_err) begin
                            match_cnt <= '0;
                            delay_q   <= (delay_q == DLY_W'(MAX_DLY - 1)) ? '0 : delay_q + DLY_W'(1);
                        end else if (acq_done) begin
                            match_cnt   <= '0;
                            run_cnt     <= '0;
                            sym_cnt     <= '0;
                            bit_acc     <= '0;
                            sym_acc     <= '0;
                            win_count_q <= '0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        // loss of lock outranks a window end: the window is dropped unpublished
                        if (loss) begin
                            run_cnt <= '0;
                            sym_cnt <= '0;
                            bit_acc <= '0;
                            sym_acc <= '0;
                        end else begin
                            run_cnt <= sym_err ? run_cnt + RUN_W'(1) : '0;
                            sym_cnt <= sym_cnt + WIN_LOG2'(1);
                            if (win_end) begin
                                bit_errs_q  <= bit_acc_nxt;
                                sym_errs_q  <= sym_acc_nxt;
                                done_q      <= 1'b1;
                                win_count_q <= sat_inc16(win_count_q);
                                bit_acc     <= '0;
                                sym_acc     <= '0;
                            end else begin
                                bit_acc <= bit_acc_nxt;
                                sym_acc <= sym_acc_nxt;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        locked = (state_q == ST_MEASURE);
    end

    assign delay     = delay_q;
    assign done      = done_q;
    assign bit_errs  = bit_errs_q;
    assign sym_errs  = sym_errs_q;
    assign win_count = win_count_q;

endmodule

// File: tb/tb_ber_meter.sv
// Directed bench for ber_meter with a window-result scoreboard (WIN_LOG2=8).
module tb_ber_meter;

    localparam int WIN = 256;

    logic        clk = 1'b0;
    logic        reset, sym_clk_ena, enable, clear;
    logic [1:0]  ref_i, ref_q, rx_i, rx_q;
`ifdef BER_ERR_INJECT_EN
    logic        err_inject;
`endif
    logic        locked, done;
    logic [5:0]  delay;
    logic [31:0] bit_errs, sym_errs;
    logic [15:0] win_count;

    typedef struct {
        int bits;
        int syms;
        int wins;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] hist[$];
    int         checks = 0;
    int         failures = 0;
    int         dly_true;
    bit         model_meas;
    int         mcnt, bacc, sacc, win_exp, last_bit, last_sym;

    ber_meter #(
        .MAX_DLY  (64),
        .DLY_W    (6),
        .ACQ_LEN  (32),
        .LOSS_LEN (16),
        .WIN_LOG2 (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sym_clk_ena (sym_clk_ena),
        .enable      (enable),
        .clear       (clear),
`ifdef BER_ERR_INJECT_EN
        .err_inject  (err_inject),
`endif
        .ref_i       (ref_i),
        .ref_q       (ref_q),
        .rx_i        (rx_i),
        .rx_q        (rx_q),
        .locked      (locked),
        .delay       (delay),
        .done        (done),
        .bit_errs    (bit_errs),
        .sym_errs    (sym_errs),
        .win_count   (win_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One symbol: rx is the reference from dly_true+1 strobes ago, xored with mask.
    task automatic strobe(input logic [3:0] mask, input logic inj);
        logic [3:0] r, rx, eff;
        bit         meas_now, exp_done;
        exp_t       e;
        r   = 4'($urandom);
        rx  = (hist.size() > dly_true) ? (hist[dly_true] ^ mask) : 4'($urandom);
        eff = mask;
`ifdef BER_ERR_INJECT_EN
        err_inject = inj;
        if (inj) eff = eff ^ 4'b0100;
`else
        if (inj) $display("note: err_inject not present in this build");
`endif
        ref_i = r[3:2];
        ref_q = r[1:0];
        rx_i  = rx[3:2];
        rx_q  = rx[1:0];
        sym_clk_ena = 1'b1;
        meas_now = model_meas;
        hist.push_front(r);
        if (hist.size() > 80) void'(hist.pop_back());
        @(posedge clk); #1;
        sym_clk_ena = 1'b0;
`ifdef BER_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        exp_done = 1'b0;
        if (meas_now) begin
            mcnt++;
            bacc += $countones(eff);
            sacc += (eff != 4'd0) ? 1 : 0;
            if (mcnt == WIN) begin
                win_exp++;
                e.bits = bacc; e.syms = sacc; e.wins = win_exp;
                sb.push_back(e);
                exp_done = 1'b1;
                mcnt = 0; bacc = 0; sacc = 0;
            end
        end
        if (done || exp_done) chk("done_pulse", done, exp_done);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk("bit_errs", bit_errs, e.bits);
            chk("sym_errs", sym_errs, e.syms);
            chk("win_count", win_count, e.wins);
            last_bit = e.bits;
            last_sym = e.syms;
        end
        if (model_meas && !locked) begin
            model_meas = 1'b0;
        end else if (!model_meas && locked) begin
            model_meas = 1'b1;
            mcnt = 0; bacc = 0; sacc = 0; win_exp = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input int n, input logic [3:0] mask, input logic inj);
        for (int i = 0; i < n; i++) strobe(mask, inj);
    endtask

    task automatic wait_lock(input int max_strobes, output int n);
        n = 0;
        while (!locked && n < max_strobes) begin
            strobe(4'd0, 1'b0);
            n++;
        end
        chk("lock_reached", locked, 1'b1);
    endtask

    initial begin
        int  n;
        bit  saw_lock;
        reset = 1'b1; enable = 1'b0; clear = 1'b0; sym_clk_ena = 1'b0;
        ref_i = '0; ref_q = '0; rx_i = '0; rx_q = '0;
`ifdef BER_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        dly_true = 7; model_meas = 1'b0;
        mcnt = 0; bacc = 0; sacc = 0; win_exp = 0; last_bit = 0; last_sym = 0;

        #2 reset = 1'b0;
        #2;
        chk("rst_locked", locked, 1'b0);
        chk("rst_delay", delay, 6'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_bit_errs", bit_errs, 32'd0);
        chk("rst_sym_errs", sym_errs, 32'd0);
        chk("rst_win_count", win_count, 16'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // clean link at delay 7: fill 64, 7 mismatching delays, 32 matches
        enable = 1'b1;
        wait_lock(400, n);
        chk("lock7_latency_min", n >= 103, 1'b1);
        chk("lock7_delay", delay, 6'd7);
        run(2 * WIN, 4'd0, 1'b0);

        // 10 single-bit errors on rx_q[1] inside one window, then a clean window
        run(10, 4'b0010, 1'b0);
        run(WIN - 10, 4'd0, 1'b0);
        chk("win_err_bits_seen", last_bit, 10);
        run(WIN, 4'd0, 1'b0);

        // 16 fully inverted symbols drop lock on the 16th strobe
        run(15, 4'hF, 1'b0);
        chk("loss_still_locked", locked, 1'b1);
        run(1, 4'hF, 1'b0);
        chk("loss_unlocked", locked, 1'b0);
        wait_lock(200, n);
        chk("relock_delay", delay, 6'd7);

`ifdef BER_ERR_INJECT_EN
        run(3, 4'd0, 1'b1);
        chk("inject_no_loss", locked, 1'b1);
        run(WIN - 3, 4'd0, 1'b0);
        chk("inject_bits", last_bit, 3);
        chk("inject_syms", last_sym, 3);
`endif

        // clear restarts the search but leaves published results untouched
        run(40, 4'd0, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        chk("clear_unlocked", locked, 1'b0);
        chk("clear_win_hold", win_count, win_exp);
        chk("clear_bits_hold", bit_errs, last_bit);
        model_meas = 1'b0;
        wait_lock(400, n);
        chk("clear_relock_delay", delay, 6'd7);
        run(WIN, 4'd0, 1'b0);

        // enable low mid-window: IDLE, results hold
        run(100, 4'd0, 1'b0);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_unlocked", locked, 1'b0);
        chk("dis_win_hold", win_count, 16'd1);
        chk("dis_bits_hold", bit_errs, last_bit);
        chk("dis_delay_hold", delay, 6'd7);
        model_meas = 1'b0;

        // deepest tap: search wraps up through 63
        dly_true = 63;
        enable = 1'b1;
        wait_lock(600, n);
        chk("lock63_latency_min", n >= 159, 1'b1);
        chk("lock63_delay", delay, 6'd63);
        run(WIN, 4'd0, 1'b0);

        // asynchronous reset mid-window
        run(50, 4'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_locked", locked, 1'b0);
        chk("arst_delay", delay, 6'd0);
        chk("arst_done", done, 1'b0);
        chk("arst_bit_errs", bit_errs, 32'd0);
        chk("arst_sym_errs", sym_errs, 32'd0);
        chk("arst_win_count", win_count, 16'd0);
        model_meas = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        // delay beyond the line must never lock
        dly_true = 64;
        saw_lock = 1'b0;
        for (int i = 0; i < 600; i++) begin
            strobe(4'd0, 1'b0);
            if (locked) saw_lock = 1'b1;
        end
        chk("dly64_never_locks", saw_lock, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
